// File: rtl/adder_rr_sequencer_if.sv
// Request/response bundle for adder_rr_sequencer: NREQ request slices in, one tagged result out.
// master = requesters plus result consumer, slave = the sequencer.
interface adder_rr_sequencer_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    localparam int unsigned DW = 26;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [DW*NREQ-1:0] req_a;
    logic [DW*NREQ-1:0] req_b;
    logic [NREQ-1:0]    req_cin;
    logic [NREQ-1:0]    req_chain;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [DW-1:0]      rsp_sum;
    logic               rsp_cout;
    logic [IDW-1:0]     rsp_id;
    logic               rsp_last;

    modport master (
        output req_valid, req_a, req_b, req_cin, req_chain, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_last
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_chain, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_last
    );
endinterface

// File: rtl/adder_rr_sequencer.sv
// Round-robin sharing of one 26-bit adder among NREQ requesters, with chained
// multi-word adds that lock the grant and forward carry through carry_q.
module adder_rr_sequencer #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    adder_rr_sequencer_if.slave bus
);
    localparam int unsigned DW = 26;
    localparam int unsigned AW = DW + 1;

    typedef enum logic {ARB, LOCK} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] owner;
    logic           carry_q;

    logic           valid_q;
    logic [DW-1:0]  sum_q;
    logic           cout_q;
    logic [IDW-1:0] id_q;
    logic           last_q;

    logic [IDW-1:0] gnt_idx;
    logic           gnt_found;
    logic           slot_free;
    logic           accept;
    logic [DW-1:0]  op_a;
    logic [DW-1:0]  op_b;
    logic           op_cin;
    logic           op_chain;
    logic [AW-1:0]  add_res;
    logic [IDW-1:0] ptr_next;

    // Grant selection: owner only while locked, else first valid from ptr upward with wrap
    always_comb begin
        int unsigned j;
        j         = 0;
        gnt_found = 1'b0;
        gnt_idx   = owner;
        if (state == LOCK) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (owner == IDW'(i) && bus.req_valid[i]) begin
                    gnt_found = 1'b1;
                end
            end
        end else begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                j = (32'(ptr) + k) % NREQ;
                for (int unsigned i = 0; i < NREQ; i++) begin
                    if (!gnt_found && j == i && bus.req_valid[i]) begin
                        gnt_found = 1'b1;
                        gnt_idx   = IDW'(i);
                    end
                end
            end
        end
    end

    // Operand mux from the granted slice; a locked chain takes its carry from carry_q
    always_comb begin
        op_a     = '0;
        op_b     = '0;
        op_cin   = 1'b0;
        op_chain = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                op_a     = bus.req_a[DW*i +: DW];
                op_b     = bus.req_b[DW*i +: DW];
                op_cin   = bus.req_cin[i];
                op_chain = bus.req_chain[i];
            end
        end
        if (state == LOCK) begin
            op_cin = carry_q;
        end
    end

    assign add_res   = {1'b0, op_a} + {1'b0, op_b} + AW'(op_cin);
    assign slot_free = ~valid_q | bus.rsp_ready;
    assign accept    = gnt_found & slot_free & ~rst;
    assign ptr_next  = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDW'(1);

    always_comb begin
        bus.req_ready = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            bus.req_ready[i] = accept && (gnt_idx == IDW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB;
            ptr     <= '0;
            owner   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            id_q    <= '0;
            last_q  <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            sum_q   <= add_res[DW-1:0];
            cout_q  <= add_res[DW];
            id_q    <= gnt_idx;
            last_q  <= ~op_chain;
            carry_q <= add_res[DW];
            if (op_chain) begin
                state <= LOCK;
                owner <= gnt_idx;
            end else begin
                state <= ARB;
                ptr   <= ptr_next;
            end
        end else if (bus.rsp_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid = valid_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = cout_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_last  = last_q;
endmodule

// File: tb/tb_adder_rr_sequencer.sv
// Directed bench for adder_rr_sequencer: expected results queued at issue time,
// a forked monitor pops and compares on every result handshake.
module tb_adder_rr_sequencer;
    logic clk;
    logic rst;

    adder_rr_sequencer_if #(.NREQ(4)) bus ();

    adder_rr_sequencer #(.NREQ(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [25:0] sum;
        logic        cout;
        logic [1:0]  id;
        logic        last;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [25:0] fair_sum [4] = '{26'd7, 26'd1011, 26'd2013, 26'd3017};
    int          fair_ord [6] = '{0, 1, 2, 3, 0, 1};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [25:0] a, input logic [25:0] b,
                           input logic cin, input logic chain);
        bus.req_a[26*i +: 26] = a;
        bus.req_b[26*i +: 26] = b;
        bus.req_cin[i]        = cin;
        bus.req_chain[i]      = chain;
        bus.req_valid[i]      = 1'b1;
    endtask

    task automatic clr_req(input int i);
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic clr_all();
        bus.req_valid = '0;
    endtask

    task automatic push(input logic [25:0] s, input logic c, input logic [1:0] id, input logic l);
        rsp_t e;
        e.sum  = s;
        e.cout = c;
        e.id   = id;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        chk({tag, "_rsp_sum"},   32'(bus.rsp_sum),   0);
        chk({tag, "_rsp_cout"},  32'(bus.rsp_cout),  0);
        chk({tag, "_rsp_id"},    32'(bus.rsp_id),    0);
        chk({tag, "_rsp_last"},  32'(bus.rsp_last),  0);
    endtask

    task automatic run_monitor();
        rsp_t got;
        rsp_t e;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid && bus.rsp_ready) begin
                got = {bus.rsp_sum, bus.rsp_cout, bus.rsp_id, bus.rsp_last};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got sum=%h cout=%b id=%0d last=%b with nothing expected",
                             got.sum, got.cout, got.id, got.last);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL rsp_payload: got sum=%h cout=%b id=%0d last=%b expected sum=%h cout=%b id=%0d last=%b",
                                 got.sum, got.cout, got.id, got.last, e.sum, e.cout, e.id, e.last);
                    end
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = '0;
        bus.req_chain = '0;
        fork
            run_monitor();
        join_none

        // ready must stay low while reset is held
        #1;
        set_req(0, 26'h1, 26'h1, 1'b0, 1'b0);
        #1;
        chk("ready_in_reset", 32'(bus.req_ready), 0);
        clr_all();
        cyc();
        cyc();
        rst = 1'b0;
        chk_reset_outputs("reset");

        // single beat with carry-out
        set_req(0, 26'h3FFFFFF, 26'h1, 1'b0, 1'b0);
        push(26'h0, 1'b1, 2'd0, 1'b1);
        #1;
        chk("single_ready", 32'(bus.req_ready), 32'h1);
        cyc();
        clr_req(0);
        chk("single_valid", 32'(bus.rsp_valid), 1);

        // ptr advanced to 1: req1 wins over req0, then req0
        set_req(0, 26'd1, 26'd2, 1'b1, 1'b0);
        set_req(1, 26'd10, 26'd20, 1'b0, 1'b0);
        #1;
        chk("ptr_after_single", 32'(bus.req_ready), 32'h2);
        push(26'd30, 1'b0, 2'd1, 1'b1);
        cyc();
        #1;
        chk("rr_wrap_to_req0", 32'(bus.req_ready), 32'h1);
        push(26'd4, 1'b0, 2'd0, 1'b1);
        cyc();
        clr_all();
        cyc();

        // fairness from a fresh ptr=0
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 26'(1000 * i + 7), 26'(3 * i), 1'(i % 2), 1'b0);
        end
        for (int k = 0; k < 6; k++) begin
            logic [3:0] v;
            v = 4'b0001 << fair_ord[k];
            #1;
            chk("fair_ready", 32'(bus.req_ready), 32'(v));
            push(fair_sum[fair_ord[k]], 1'b0, 2'(fair_ord[k]), 1'b1);
            cyc();
            chk("fair_valid", 32'(bus.rsp_valid), 1);
        end
        clr_all();
        cyc();

        // 78-bit chain on req2 (ptr=2) with everyone else waiting
        set_req(0, 26'd11, 26'd0, 1'b0, 1'b0);
        set_req(1, 26'd22, 26'd0, 1'b0, 1'b0);
        set_req(3, 26'd33, 26'd0, 1'b0, 1'b0);
        set_req(2, 26'h3FFFFFF, 26'h1, 1'b0, 1'b1);
        #1;
        chk("chain_beat1_ready", 32'(bus.req_ready), 32'h4);
        push(26'h0, 1'b1, 2'd2, 1'b0);
        cyc();
        set_req(2, 26'h3FFFFFF, 26'h0, 1'b0, 1'b1);
        #1;
        chk("chain_beat2_ready", 32'(bus.req_ready), 32'h4);
        push(26'h0, 1'b1, 2'd2, 1'b0);
        cyc();
        set_req(2, 26'd5, 26'd0, 1'b0, 1'b0);
        #1;
        chk("chain_beat3_ready", 32'(bus.req_ready), 32'h4);
        push(26'd6, 1'b0, 2'd2, 1'b1);
        cyc();
        clr_req(2);
        #1;
        chk("chain_next_req3", 32'(bus.req_ready), 32'h8);
        push(26'd33, 1'b0, 2'd3, 1'b1);
        cyc();
        clr_all();

        // backpressure: req3 result held, req1 waits
        bus.rsp_ready = 1'b0;
        set_req(1, 26'h123, 26'h456, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_ready_low", 32'(bus.req_ready), 0);
            chk("bp_id_stable", 32'(bus.rsp_id), 3);
            chk("bp_sum_stable", 32'(bus.rsp_sum), 32'd33);
            cyc();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.req_ready), 32'h2);
        push(26'h57A, 1'b0, 2'd1, 1'b1);
        cyc();
        clr_req(1);
        chk("bp_overwrite_valid", 32'(bus.rsp_valid), 1);
        chk("bp_overwrite_id", 32'(bus.rsp_id), 1);
        cyc();

        // owner stall: req0 locks (ptr=2), goes quiet for 3 cycles while req1 waits
        set_req(0, 26'h3FFFFFF, 26'h3FFFFFF, 1'b0, 1'b1);
        #1;
        chk("stall_lock_ready", 32'(bus.req_ready), 32'h1);
        push(26'h3FFFFFE, 1'b1, 2'd0, 1'b0);
        cyc();
        clr_req(0);
        set_req(1, 26'h10, 26'h20, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_no_grant", 32'(bus.req_ready), 0);
            cyc();
        end
        set_req(0, 26'h0, 26'h0, 1'b0, 1'b0);
        #1;
        chk("stall_owner_back", 32'(bus.req_ready), 32'h1);
        push(26'h1, 1'b0, 2'd0, 1'b1);
        cyc();
        clr_req(0);
        #1;
        chk("stall_then_req1", 32'(bus.req_ready), 32'h2);
        push(26'h30, 1'b0, 2'd1, 1'b1);
        cyc();
        clr_all();
        cyc();

        // reset mid-chain with the beat-1 result still pending
        bus.rsp_ready = 1'b0;
        set_req(3, 26'h3FFFFFF, 26'h1, 1'b0, 1'b1);
        #1;
        chk("rmc_beat1_ready", 32'(bus.req_ready), 32'h8);
        cyc();
        clr_req(3);
        chk("rmc_pending", 32'(bus.rsp_valid), 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_reset_outputs("rmc");
        bus.rsp_ready = 1'b1;
        set_req(1, 26'd7, 26'd8, 1'b0, 1'b0);
        set_req(3, 26'd5, 26'd0, 1'b0, 1'b0);
        #1;
        chk("rmc_ptr0_req1", 32'(bus.req_ready), 32'h2);
        push(26'd15, 1'b0, 2'd1, 1'b1);
        cyc();
        #1;
        chk("rmc_req3_fresh", 32'(bus.req_ready), 32'h8);
        push(26'd5, 1'b0, 2'd3, 1'b1);
        cyc();
        clr_all();
        cyc();
        cyc();

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/adder_rr_sequencer.md
# adder_rr_sequencer

Round-robin scheduler that shares one instance of the team's 26-bit Ling/Harris prefix `adder` among NREQ requesters. Each accepted request is one adder beat. A requester can lock the adder for a multi-word add by marking beats as chained. In that case the carry-out of each beat is registered and used as the carry-in of that requester's next beat. Results leave through a one-deep registered output stage with valid/ready backpressure, tagged with the requester index.

## Interface
- NREQ, 4, number of requesters (1..16).
- IDW, $clog2(NREQ) (minimum 1), width of the requester tag.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  NREQ  bit i: requester i presents a beat.
- req_ready  output  NREQ  bit i: beat i accepted this cycle.
- req_a  input  26*NREQ  operand A; slice [26*i+25:26*i] belongs to requester i.
- req_b  input  26*NREQ  operand B, same slicing as req_a.
- req_cin  input  NREQ  carry-in; used only on the first beat of an operation.
- req_chain  input  NREQ  1 = more beats follow for this operation (hold grant).
- rsp_valid  output  1  result register full.
- rsp_ready  input  1  consumer accepts the result.
- rsp_sum  output  26  sum from the adder.
- rsp_cout  output  1  carry-out from the adder.
- rsp_id  output  IDW  index of the requester that owns the result.
- rsp_last  output  1  1 = final beat of its operation (the accepted beat's chain bit was 0).

## Operation
- Output slot free: slot_free = ~rsp_valid | rsp_ready.
- States:
  - ARB: the grant goes to the first requester with valid=1, searching from ptr upward with wrap NREQ-1 -> 0.
  - LOCK: only the owner can be granted.
- Handshake: req_ready[i] = grant[i] & slot_free. At most one ready bit is high at a time.
- Ready depends combinationally on req_valid and rsp_ready. A requester must not make req_valid depend on req_ready. Once req_valid is asserted, its operands and chain bit stay stable until accepted.
- Adder inputs come from the granted slice:
  - In ARB, cin = req_cin[grant].
  - In LOCK, cin = carry_q and req_cin is ignored.
- On acceptance of a beat from requester i:
  - Load rsp_sum, rsp_cout, rsp_id=i and rsp_last=~req_chain[i] into the output register; set rsp_valid.
  - carry_q <= adder cout.
  - If chain=1: enter (or stay in) LOCK with owner=i; ptr is unchanged.
  - If chain=0: enter ARB and set ptr <= i+1, wrapping to 0 at NREQ.
- With no acceptance and rsp_ready=1: rsp_valid <= 0, all other state is held.
- With no requester valid in ARB: no grant is issued and ptr holds.
- In LOCK with the owner's valid=0: stay in LOCK. No other requester is granted, and there is no timeout.
- rsp_ready=0 with rsp_valid=1: no acceptance. The output register and carry_q hold.
- Simultaneous drain and accept (rsp_valid=1, rsp_ready=1, grant present): the new beat overwrites the register and rsp_valid stays 1. This gives full throughput of 1 beat/cycle.
- NREQ=1: ptr is a constant 0; the LOCK behaviour is unchanged.

## Timing
- Reset values: rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, rsp_last=0, state=ARB, ptr=0, carry_q=0.
- req_ready is combinational and goes low during rst.
- Reset asserted mid-chain aborts the operation:
  - LOCK is dropped and carry_q is cleared.
  - Any pending result is discarded.
  - No partial-chain result is emitted after reset.
- Latency: a beat accepted at edge N is visible on rsp_* after edge N (rsp_valid=1 in cycle N+1).
- The adder path is purely combinational inside one cycle. The only registers are the output register, carry_q, state, owner and ptr.
- Chained beats can issue back-to-back. The carry for beat k+1 comes from carry_q, which is written at the acceptance edge of beat k.

## Test plan
- Single beat: reset, then req0 with a=26'h3FFFFFF, b=1, cin=0, chain=0.
  - Expect rsp_sum=0, rsp_cout=1, rsp_id=0, rsp_last=1 one cycle after acceptance.
  - Expect ptr=1 afterwards.
- Round-robin fairness: all 4 requesters hold valid with chain=0 and rsp_ready=1.
  - Grants occur in order 0,1,2,3,0,1, one per cycle.
  - rsp_valid stays 1 continuously.
- 78-bit chain: req2 sends 3 beats.
  - Beat 1: a=26'h3FFFFFF, b=1, cin=0, chain=1. Expect sum=0, cout=1, last=0.
  - Beat 2: a=26'h3FFFFFF, b=0, cin=0, chain=1. Expect sum=0, cout=1, last=0.
  - Beat 3: a=5, b=0, cin=0, chain=0. Expect sum=6, cout=0, last=1.
  - Throughout, req0/1/3 are valid and never granted.
  - After beat 3 the next grant goes to req3.
- Backpressure: hold rsp_ready=0 for 5 cycles with req1 valid.
  - req_ready=0 throughout; rsp_* stable.
  - Raising rsp_ready drains the result and accepts req1 in the same cycle.
- Owner stall: in LOCK owner=0, drop req_valid[0] for 3 cycles while req1 is valid.
  - No grant during those cycles.
  - Beat 2 from req0 then uses the stored carry.
- Reset mid-chain: assert rst after beat 1 of a chain, for 1 cycle.
  - All outputs reach their reset values.
  - The next beat from any requester is arbitrated from ptr=0 and uses req_cin, not the old carry.
